// File: rtl/wired_cdb_tx_if.sv
// Result payload type and the bundled FU/CDB handshake bus of the writeback buffer.
// master = the writeback buffer, slave = the functional unit plus the CDB arbiter port.
package wired_cdb_pkg;

  typedef struct packed {
    logic        valid;
    logic [5:0]  tag;
    logic [31:0] data;
  } pipeline_cdb_t;

endpackage

interface wired_cdb_tx_if #(
  parameter int DEPTH = 4
);
  import wired_cdb_pkg::*;

  logic                     flush_i;
  logic                     fu_valid_i;
  pipeline_cdb_t            fu_cdb_i;
  logic                     fu_ready_o;
  pipeline_cdb_t            cdb_o;
  logic                     cdb_ready_i;
  logic [$clog2(DEPTH):0]   count_o;
  logic [7:0]               stall_cnt_o;

  modport master (
    input  flush_i, fu_valid_i, fu_cdb_i, cdb_ready_i,
    output fu_ready_o, cdb_o, count_o, stall_cnt_o
  );

  modport slave (
    output flush_i, fu_valid_i, fu_cdb_i, cdb_ready_i,
    input  fu_ready_o, cdb_o, count_o, stall_cnt_o
  );

endinterface

// File: rtl/wired_cdb_tx.sv
// Writeback buffer between one functional unit and one CDB arbiter input: a
// registered circular FIFO with flush, occupancy count and a back-pressure stall counter.
module wired_cdb_tx
  import wired_cdb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  wired_cdb_tx_if.master        bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]  head;
  logic [PW-1:0]  tail;
  logic [CW-1:0]  count;
  logic [7:0]     stall_cnt;
  pipeline_cdb_t  mem [DEPTH];

  logic           not_empty;
  logic           fu_ready;
  logic           push;
  logic           pop;
  pipeline_cdb_t  head_entry;

  // Outputs depend only on registered state, so the arbiter's ready can never
  // loop back combinationally into the FU handshake.
  assign not_empty = (count != '0);
  assign fu_ready  = (count < CW'(DEPTH));
  assign push      = bus.fu_valid_i && fu_ready;
  assign pop       = not_empty && bus.cdb_ready_i;

  always_comb begin
    head_entry = '0;
    if (not_empty) begin
      head_entry       = mem[head];
      head_entry.valid = 1'b1;
    end
  end

  assign bus.cdb_o       = head_entry;
  assign bus.fu_ready_o  = fu_ready;
  assign bus.count_o     = count;
  assign bus.stall_cnt_o = stall_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      stall_cnt <= '0;
    end else if (bus.flush_i) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      stall_cnt <= '0;
    end else begin
      // Power-of-two depth: pointer increment wraps DEPTH-1 -> 0 for free.
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (not_empty && !bus.cdb_ready_i)
        stall_cnt <= (stall_cnt != 8'hFF) ? stall_cnt + 8'd1 : stall_cnt;
      else
        stall_cnt <= '0;
    end
  end

  // NOTE: payload storage has no reset; an entry is only visible once count
  // covers it, and leaving it unreset keeps it a plain RAM without reset fan-out.
  always_ff @(posedge clk) begin
    if (push && !bus.flush_i)
      mem[tail] <= bus.fu_cdb_i;
  end

endmodule
